// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among NUM_MASTERS
// requesters, one transaction outstanding at a time, with a stall watchdog.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255,
    localparam int ID_W       = $clog2(NUM_MASTERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_req_valid,
    output logic [NUM_MASTERS-1:0]      m_req_ready,
    input  logic [NUM_MASTERS*AW-1:0]   m_req_addr,
    input  logic [NUM_MASTERS-1:0]      m_req_wen,
    input  logic [NUM_MASTERS*DW-1:0]   m_req_wdata,
    input  logic [NUM_MASTERS*DW/8-1:0] m_req_wmask,
    output logic [NUM_MASTERS-1:0]      m_rsp_valid,
    output logic [DW-1:0]               m_rsp_rdata,
    output logic                        m_rsp_err,
    output logic                        s_req_valid,
    input  logic                        s_req_ready,
    output logic [AW-1:0]               s_req_addr,
    output logic                        s_req_wen,
    output logic [DW-1:0]               s_req_wdata,
    output logic [DW/8-1:0]             s_req_wmask,
    input  logic                        s_rsp_valid,
    input  logic [DW-1:0]               s_rsp_rdata,
    input  logic                        s_rsp_err,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id
);

    localparam int WB = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Handshakes: a request transfers on a cycle where valid and ready are both
    // high; valid and payload stay stable until then. Responses are single-cycle
    // pulses with no backpressure.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W:0]    sum;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [NUM_MASTERS-1:0] grant_onehot;
    logic [ID_W-1:0]  next_ptr;
    logic             timeout_hit;

    logic [AW-1:0]    sel_addr;
    logic             sel_wen;
    logic [DW-1:0]    sel_wdata;
    logic [WB-1:0]    sel_wmask;

    // First valid master at or after ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_MASTERS))
                sum = sum - (ID_W+1)'(NUM_MASTERS);
            if (!win_found && m_req_valid[sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr     = '0;
        sel_wen      = 1'b0;
        sel_wdata    = '0;
        sel_wmask    = '0;
        win_onehot   = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            win_onehot[i]   = win_found && (win_id == ID_W'(i));
            grant_onehot[i] = (grant_id == ID_W'(i));
            if (win_id == ID_W'(i)) begin
                sel_addr  = m_req_addr[i*AW +: AW];
                sel_wen   = m_req_wen[i];
                sel_wdata = m_req_wdata[i*DW +: DW];
                sel_wmask = m_req_wmask[i*WB +: WB];
            end
        end
    end

    assign next_ptr    = (win_id == ID_W'(NUM_MASTERS - 1)) ? '0 : win_id + 1'b1;
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Gated by rst so nothing is granted while reset is held.
    assign m_req_ready = (rst && state == IDLE) ? win_onehot : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            s_req_valid <= 1'b0;
            s_req_addr  <= '0;
            s_req_wen   <= 1'b0;
            s_req_wdata <= '0;
            s_req_wmask <= '0;
            m_rsp_valid <= '0;
            m_rsp_rdata <= '0;
            m_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        s_req_addr  <= sel_addr;
                        s_req_wen   <= sel_wen;
                        s_req_wdata <= sel_wdata;
                        s_req_wmask <= sel_wmask;
                        s_req_valid <= 1'b1;
                        grant_id    <= win_id;
                        ptr         <= next_ptr;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt_inc;
                    if (s_req_ready) begin
                        s_req_valid <= 1'b0;
                        state       <= WAIT;
                    end else if (timeout_hit) begin
                        s_req_valid <= 1'b0;
                        m_rsp_valid <= grant_onehot;
                        m_rsp_rdata <= '0;
                        m_rsp_err   <= 1'b1;
                        state       <= RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (s_rsp_valid) begin
                        m_rsp_valid <= grant_onehot;
                        m_rsp_rdata <= s_rsp_rdata;
                        m_rsp_err   <= s_rsp_err;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        m_rsp_valid <= grant_onehot;
                        m_rsp_rdata <= '0;
                        m_rsp_err   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    m_rsp_valid <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
